// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if: operand stream, DSP slice and result stream signals of the MAC sequencer
interface dsp_mac_sequencer_if;
  logic s_valid;
  logic s_ready;
  logic signed [17:0] s_a;
  logic signed [17:0] s_b;
  logic s_last;
  logic signed [17:0] dsp_a;
  logic signed [17:0] dsp_b;
  logic [7:0] dsp_opmode;
  logic [47:0] dsp_p;
  logic dsp_carryout;
  logic m_valid;
  logic m_ready;
  logic [47:0] m_result;
  logic m_carry;
  modport master (
    input s_valid, s_a, s_b, s_last, dsp_p, dsp_carryout, m_ready,
    output s_ready, dsp_a, dsp_b, dsp_opmode, m_valid, m_result, m_carry
  );
  modport slave (
    output s_valid, s_a, s_b, s_last, dsp_p, dsp_carryout, m_ready,
    input s_ready, dsp_a, dsp_b, dsp_opmode, m_valid, m_result, m_carry
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: feeds operand pairs and opmodes to a pipelined DSP MAC and captures dot products
module dsp_mac_sequencer #(
  parameter int LAT = 4,
  parameter int OPM_DLY = 1
) (
  input logic clk,
  input logic rst,
  dsp_mac_sequencer_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, ACC = 2'd1, DRAIN = 2'd2, HOLD = 2'd3;
  localparam logic [1:0] T_BUB = 2'd0, T_FIRST = 2'd1, T_NEXT = 2'd2;
  localparam int CW = $clog2(LAT + 1);
  localparam int DW = OPM_DLY > 0 ? OPM_DLY : 1;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [1:0] line [DW];
  logic xfer;
  logic [1:0] tag;
  logic [1:0] tag_out;
  assign bus.s_ready = state == IDLE || state == ACC;
  assign bus.m_valid = state == HOLD;
  assign xfer = bus.s_valid && bus.s_ready;
  assign tag = !xfer ? T_BUB : state == IDLE ? T_FIRST : T_NEXT;
  assign tag_out = OPM_DLY == 0 ? tag : line[DW-1];
  // Operand registers and opmode, which trails the operands by OPM_DLY edges
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.dsp_a <= '0;
      bus.dsp_b <= '0;
      bus.dsp_opmode <= 8'h00;
      for (int i = 0; i < DW; i++) line[i] <= T_BUB;
    end else begin
      bus.dsp_a <= xfer ? bus.s_a : '0;
      bus.dsp_b <= xfer ? bus.s_b : '0;
      bus.dsp_opmode <= tag_out == T_FIRST ? 8'h01 : tag_out == T_NEXT ? 8'h09 : 8'h08;
      for (int i = DW - 1; i > 0; i--) line[i] <= line[i-1];
      line[0] <= tag;
    end
  // Vector sequencing, drain countdown and result capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.m_result <= '0;
      bus.m_carry <= 1'b0;
    end else begin
      if (xfer) state <= bus.s_last ? DRAIN : ACC;
      if (xfer && bus.s_last) cnt <= CW'(LAT);
      if (state == DRAIN) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state <= HOLD;
          bus.m_result <= bus.dsp_p;
          bus.m_carry <= bus.dsp_carryout;
        end
      end
      if (bus.m_valid && bus.m_ready) state <= IDLE;
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: directed scoreboard bench with a looped-back pipelined DSP slice model
module tb_dsp_mac_sequencer;
  typedef struct packed {logic [47:0] r; logic c;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int last_cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  logic [7:0] op_log[$];
  logic signed [47:0] acc = '0;
  logic in_vec = 1'b0;
  dsp_mac_sequencer_if bus();
  dsp_mac_sequencer #(.LAT(4), .OPM_DLY(1)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // DSP slice: A/B reg, M reg, then P = (op[0] ? M : 0) + (op[3] ? P : 0); opmode registered once
  logic signed [17:0] ar = '0, br = '0;
  logic signed [47:0] mr = '0, p = '0;
  logic [7:0] opr = '0;
  logic co = 1'b0;
  logic signed [47:0] dx, dz, dsum;
  assign dx = opr[0] ? mr : '0;
  assign dz = opr[3] ? p : '0;
  assign dsum = dx + dz;
  assign bus.dsp_p = p;
  assign bus.dsp_carryout = co;
  always @(posedge clk) begin
    ar <= bus.dsp_a;
    br <= bus.dsp_b;
    mr <= ar * br;
    opr <= bus.dsp_opmode;
    p <= dsp_sum_wrap(dsum);
    if (opr[0]) co <= (dx[47] == dz[47]) && (dsum[47] != dz[47]);
  end
  function automatic logic signed [47:0] dsp_sum_wrap(input logic signed [47:0] v);
    return v;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic cycle(input logic v, input logic signed [17:0] a, input logic signed [17:0] b, input logic l);
    logic signed [47:0] prod, sum;
    logic ovf, go;
    bus.s_valid = v;
    bus.s_a = a;
    bus.s_b = b;
    bus.s_last = l;
    go = v && bus.s_ready;
    @(negedge clk);
    op_log.push_back(bus.dsp_opmode);
    if (go) begin
      prod = a * b;
      sum = acc + prod;
      ovf = in_vec && (acc[47] == prod[47]) && (sum[47] != acc[47]);
      acc = in_vec ? sum : prod;
      in_vec = !l;
      if (l) begin
        sb.push_back('{acc, ovf});
        last_cyc = cyc;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
  endtask
  task automatic wait_result(input int hold);
    int n;
    exp_t e;
    n = 0;
    bus.m_ready = 1'b0;
    while (!bus.m_valid && n < 40) begin
      cycle(1'b0, '0, '0, 1'b0);
      n++;
    end
    chk("m_valid_timeout", bus.m_valid, 1);
    chk("scoreboard_nonempty", sb.size() != 0, 1);
    if (bus.m_valid && sb.size() != 0) begin
      e = sb.pop_front();
      chk("latency", cyc - last_cyc, 4);
      chk("m_result", bus.m_result, e.r);
      chk("m_carry", bus.m_carry, e.c);
      for (int k = 0; k < hold; k++) begin
        cycle(1'b0, '0, '0, 1'b0);
        chk("hold_result", bus.m_result, e.r);
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_s_ready", bus.s_ready, 0);
        chk("hold_opmode", bus.dsp_opmode, 8'h08);
      end
      bus.m_ready = 1'b1;
      cycle(1'b0, '0, '0, 1'b0);
      bus.m_ready = 1'b0;
      chk("release_valid", bus.m_valid, 0);
      chk("release_s_ready", bus.s_ready, 1);
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dsp_a"}, bus.dsp_a, 0);
    chk({tag, "_dsp_b"}, bus.dsp_b, 0);
    chk({tag, "_opmode"}, bus.dsp_opmode, 8'h00);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_result"}, bus.m_result, 0);
    chk({tag, "_m_carry"}, bus.m_carry, 0);
    chk({tag, "_s_ready"}, bus.s_ready, 1);
  endtask
  initial begin
    bus.s_valid = 1'b0;
    bus.s_a = '0;
    bus.s_b = '0;
    bus.s_last = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    cycle(1'b1, 18'sd2, 18'sd3, 1'b0);
    cycle(1'b1, 18'sd4, 18'sd5, 1'b0);
    cycle(1'b1, -18'sd1, 18'sd7, 1'b1);
    wait_result(0);
    op_log.delete();
    cycle(1'b1, 18'sd2, 18'sd3, 1'b0);
    cycle(1'b1, 18'sd4, 18'sd5, 1'b0);
    repeat (3) cycle(1'b0, '0, '0, 1'b0);
    cycle(1'b1, -18'sd1, 18'sd7, 1'b1);
    wait_result(0);
    chk("opmode_0", op_log[1], 8'h01);
    chk("opmode_1", op_log[2], 8'h09);
    chk("opmode_2", op_log[3], 8'h08);
    chk("opmode_3", op_log[4], 8'h08);
    chk("opmode_4", op_log[5], 8'h08);
    chk("opmode_5", op_log[6], 8'h09);
    cycle(1'b1, -18'sd131072, -18'sd131072, 1'b1);
    wait_result(5);
    for (int k = 0; k < 8192; k++) cycle(1'b1, -18'sd131072, -18'sd131072, k == 8191);
    wait_result(0);
    cycle(1'b1, 18'sd100, 18'sd100, 1'b0);
    cycle(1'b1, 18'sd100, 18'sd100, 1'b0);
    rst = 1'b1;
    in_vec = 1'b0;
    #1;
    chk_reset_outputs("midvec_reset");
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 18'sd1, 18'sd1, 1'b1);
    wait_result(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dsp_mac_sequencer.md
DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Parameters
REQ-001 SHALL provide parameter LAT, default 4: rising edges from the edge loading dsp_a/dsp_b with an operand pair to the edge where the resulting P is valid for capture.
REQ-002 SHALL provide parameter OPM_DLY, default 1: rising edges between the operand load and the corresponding dsp_opmode load; legal range 0..LAT-2.

Interface
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 s_valid  in  1  operand pair valid.
REQ-006 s_ready  out  1  sequencer accepts a pair.
REQ-007 s_a, s_b  in  18 each  signed multiplicand and multiplier.
REQ-008 s_last  in  1  marks the final pair of a dot-product vector.
REQ-009 dsp_a, dsp_b  out  18 each  registered operands to DSP slice a/b ports.
REQ-010 dsp_opmode  out  8  registered opmode to DSP slice.
REQ-011 dsp_p  in  48  DSP slice P output.
REQ-012 dsp_carryout  in  1  DSP slice carry-out.
REQ-013 m_valid  out  1  result valid.
REQ-014 m_ready  in  1  downstream accepts result.
REQ-015 m_result  out  48  captured accumulated dot product.
REQ-016 m_carry  out  1  dsp_carryout captured with m_result.

Function
REQ-017 SHALL implement states IDLE, ACC, DRAIN, HOLD; s_ready = 1 in IDLE and ACC only (combinational from state).
REQ-018 Transfer = s_valid & s_ready; on transfer dsp_a <= s_a, dsp_b <= s_b; on a non-transfer cycle dsp_a <= 0, dsp_b <= 0 (bubble).
REQ-019 Each cycle SHALL push a slot tag into an OPM_DLY-deep delay line: FIRST (transfer in IDLE), NEXT (transfer in ACC), BUBBLE (no transfer).
REQ-020 dsp_opmode SHALL be loaded from the delayed tag: FIRST -> 0x01 (X=M, Z=0), NEXT -> 0x09 (X=M, Z=P), BUBBLE -> 0x08 (X=0, Z=P, P holds); bits 7:4 always 0.
REQ-021 IDLE -> ACC on transfer with s_last=0; IDLE or ACC -> DRAIN on transfer with s_last=1 (single-pair vector legal, tag FIRST).
REQ-022 Entering DRAIN SHALL load a latency counter with LAT; counter decrements each edge in DRAIN.
REQ-023 On the LAT-th edge after the last-pair load: m_result <= dsp_p, m_carry <= dsp_carryout, state -> HOLD, m_valid = 1.
REQ-024 HOLD: m_result, m_carry stable; on m_valid & m_ready -> IDLE and m_valid = 0 from the next cycle.
REQ-025 Bubbles in ACC SHALL NOT alter the accumulation; no limit on vector length or bubble count.
REQ-026 Accumulation is the DSP's 48-bit two's-complement wrap; sequencer performs no arithmetic on dsp_p.

Reset
REQ-027 rst asserted at any time (including mid-ACC/DRAIN/HOLD) SHALL immediately force: state IDLE, counter 0, tag line BUBBLE, dsp_a=0, dsp_b=0, dsp_opmode=0x00, m_valid=0, m_result=0, m_carry=0.
REQ-028 After rst deasserts, s_ready = 1; a partially accumulated vector is discarded; next transfer starts a fresh vector (FIRST).

Verification (bench: sequencer driving the team's DSP slice at default parameters, outputs looped back)
REQ-029 Pairs (2,3),(4,5),(-1,7,last) back-to-back -> m_result = 19, m_valid rises 4 edges after the last-pair load, m_carry = 0.
REQ-030 Same vector with 3 bubble cycles between pairs 2 and 3 -> m_result = 19; dsp_opmode sequence 0x01,0x09,0x08,0x08,0x08,0x09.
REQ-031 Single pair (-131072,-131072,last) -> m_result = 17179869184 (0x0004_0000_0000).
REQ-032 Result then m_ready held low 5 cycles -> m_result and m_valid stable, s_ready = 0, dsp_opmode = 0x08; m_ready high -> IDLE next cycle, s_ready = 1.
REQ-033 rst pulsed after pairs (100,100),(100,100) with no last -> all outputs at reset values; then (1,1,last) -> m_result = 1.
